// File: rtl/spi_pkg.sv
// Shared definitions for the SPI mode-0 target.
// Contents:
//   SPI_IDLE_BYTE            - byte shifted out / reported when no data exists
//   spi_target_state_t       - target FSM states
//   SPI_SYNC_STAGES_DEFAULT  - default synchronizer depth for the SPI pins
package spi_pkg;

    localparam logic [7:0] SPI_IDLE_BYTE = 8'hFF;

    localparam int SPI_SYNC_STAGES_DEFAULT = 2;

    typedef enum logic {
        IDLE     = 1'b0,
        SELECTED = 1'b1
    } spi_target_state_t;

endpackage

// File: rtl/spi_target_sync_edge.sv
// sync_edge: N-flop synchronizer for an asynchronous pin, followed by one
// delay flop so that single-cycle rise/fall pulses can be derived in the
// clk domain.
// Ports:
//   clk    in   system clock
//   rst_n  in   synchronous active-low reset
//   din    in   asynchronous input pin
//   level  out  synchronized level (output of the last synchronizer flop)
//   rise   out  one-cycle pulse when level goes 0->1
//   fall   out  one-cycle pulse when level goes 1->0
module sync_edge
    import spi_pkg::*;
#(
    parameter int   STAGES  = SPI_SYNC_STAGES_DEFAULT,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              dly_q;
    logic              dly_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        dly_d  = sync_q[STAGES-1];
    end

    // Reset to the pin's idle value so releasing reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            dly_q  <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~dly_q;
    assign fall  = ~level & dly_q;

endmodule

// File: rtl/spi_target.sv
// spi_target: SPI mode-0 responder. sclk/cs_n/mosi are oversampled in the
// clk domain; one byte is shifted MSB-first per 8 sclk rising edges.
// Ports:
//   clk, rst_n            system clock, synchronous active-low reset
//   sclk, cs_n, mosi      asynchronous SPI pins from the initiator
//   miso                  serial data out, 1 when not selected
//   tx_data, tx_load      write into the one-deep holding register
//   tx_ready              holding register empty
//   rx_data, rx_valid     last received byte (0xFF when not valid)
//   rx_ack                consume received byte, clears rx_valid/rx_overrun
//   rx_overrun            sticky: byte completed while rx_valid was set
//   busy                  selected with a partial byte in progress
module spi_target
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = SPI_SYNC_STAGES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       rx_overrun,
    output logic       busy
);

    logic sclk_level_unused;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_level;
    logic cs_rise;
    logic cs_fall;
    logic mosi_s;
    logic mosi_rise_unused;
    logic mosi_fall_unused;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sclk),
        .level (sclk_level_unused),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (cs_n),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_mosi (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (mosi),
        .level (mosi_s),
        .rise  (mosi_rise_unused),
        .fall  (mosi_fall_unused)
    );

    spi_target_state_t state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [7:0]        rx_shift_q, rx_shift_d;
    logic [7:0]        tx_shift_q, tx_shift_d;
    logic [7:0]        hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [7:0]        rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              rx_overrun_q, rx_overrun_d;
    logic              consume;
    logic [7:0]        rx_byte;
    logic [7:0]        next_tx;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rx_shift_d   = rx_shift_q;
        tx_shift_d   = tx_shift_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        rx_overrun_d = rx_overrun_q;
        consume      = 1'b0;
        rx_byte      = {rx_shift_q[6:0], mosi_s};
        next_tx      = hold_full_q ? hold_q : SPI_IDLE_BYTE;

        // Ack is applied first so a byte completing in the same cycle wins.
        if (rx_ack) begin
            rx_valid_d   = 1'b0;
            rx_overrun_d = 1'b0;
            rx_data_d    = SPI_IDLE_BYTE;
        end

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d    = SELECTED;
                    cnt_d      = 3'd0;
                    tx_shift_d = next_tx;
                    consume    = 1'b1;
                end
            end
            SELECTED: begin
                if (cs_rise) begin
                    // Deselect drops any partial byte; holding register is kept.
                    state_d    = IDLE;
                    cnt_d      = 3'd0;
                    rx_shift_d = SPI_IDLE_BYTE;
                end else if (sclk_rise) begin
                    rx_shift_d = rx_byte;
                    cnt_d      = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        rx_data_d  = rx_byte;
                        rx_valid_d = 1'b1;
                        if (rx_valid_q && !rx_ack) begin
                            rx_overrun_d = 1'b1;
                        end
                    end
                end else if (sclk_fall) begin
                    // Counter at 0 on a fall means the byte just finished:
                    // fetch the next one instead of shifting.
                    if (cnt_q != 3'd0) begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b1};
                    end else begin
                        tx_shift_d = next_tx;
                        consume    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (consume) begin
            hold_full_d = 1'b0;
        end
        // Acceptance looks at the registered flag, so a load in the consume
        // cycle only lands if the register was already empty.
        if (tx_load && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            rx_shift_q   <= SPI_IDLE_BYTE;
            tx_shift_q   <= SPI_IDLE_BYTE;
            hold_q       <= SPI_IDLE_BYTE;
            hold_full_q  <= 1'b0;
            rx_data_q    <= SPI_IDLE_BYTE;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rx_shift_q   <= rx_shift_d;
            tx_shift_q   <= tx_shift_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_overrun_q <= rx_overrun_d;
        end
    end

    assign miso       = (state_q == SELECTED) ? tx_shift_q[7] : 1'b1;
    assign tx_ready   = ~hold_full_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign rx_overrun = rx_overrun_q;
    assign busy       = ~cs_level & (cnt_q != 3'd0);

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: a table of single-byte transfers plus
// hand-written sequences for bursts, overrun, abort, handshake collisions
// and reset mid-byte. The initiator is modelled at clk/8 (4 clk per phase).
module tb_spi_target;

    logic       clk;
    logic       rst_n;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       rx_overrun;
    logic       busy;

    int total = 0;
    int bad   = 0;

    spi_target #(.SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sclk       (sclk),
        .cs_n       (cs_n),
        .mosi       (mosi),
        .miso       (miso),
        .tx_data    (tx_data),
        .tx_load    (tx_load),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ack     (rx_ack),
        .rx_overrun (rx_overrun),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       do_load;
        logic [7:0] load_byte;
        logic [7:0] mosi_byte;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_tx(input logic [7:0] b);
        tx_data = b;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    task automatic do_ack();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
    endtask

    task automatic select();
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic deselect();
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Full byte; miso captured just before each rise. lat = clk edges from
    // the 8th rise until rx_valid is seen (0 if never / already set).
    task automatic xfer(input logic [7:0] mo, input bit ack_last,
                        output logic [7:0] mi, output int lat);
        logic v0;
        lat = 0;
        v0  = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            mosi = mo[i];
            repeat (4) @(negedge clk);
            mi[i] = miso;
            if (i == 0) v0 = rx_valid;
            sclk = 1'b1;
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                if (i == 0 && ack_last && k == 2) rx_ack = 1'b1;
                if (i == 0 && ack_last && k == 3) rx_ack = 1'b0;
                if (i == 0 && !v0 && rx_valid && lat == 0) lat = k;
            end
            sclk = 1'b0;
        end
    endtask

    task automatic partial(input logic [7:0] mo, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            mosi = mo[i];
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] mi;
        int         lat;

        vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[1] = '{1'b0, 8'h00, 8'h00, 8'hFF, 8'h00};
        vecs[2] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF};
        vecs[3] = '{1'b1, 8'h81, 8'h7E, 8'h81, 8'h7E};

        rst_n   = 1'b0;
        sclk    = 1'b0;
        cs_n    = 1'b1;
        mosi    = 1'b1;
        tx_data = 8'h00;
        tx_load = 1'b0;
        rx_ack  = 1'b0;
        repeat (3) @(negedge clk);

        chk("reset miso", miso, 1);
        chk("reset rx_data", rx_data, 8'hFF);
        chk("reset tx_ready", tx_ready, 1);
        chk("reset rx_valid", rx_valid, 0);
        chk("reset rx_overrun", rx_overrun, 0);
        chk("reset busy", busy, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table of single-byte transfers.
        for (int v = 0; v < 4; v++) begin
            if (vecs[v].do_load) begin
                load_tx(vecs[v].load_byte);
                chk($sformatf("v%0d tx_ready after load", v), tx_ready, 0);
            end
            select();
            chk($sformatf("v%0d tx_ready after select", v), tx_ready, 1);
            xfer(vecs[v].mosi_byte, 1'b0, mi, lat);
            deselect();
            chk($sformatf("v%0d miso byte", v), mi, vecs[v].exp_miso);
            chk($sformatf("v%0d rx_data", v), rx_data, vecs[v].exp_rx);
            chk($sformatf("v%0d rx_valid", v), rx_valid, 1);
            chk($sformatf("v%0d rx_valid latency", v), lat, 3);
            chk($sformatf("v%0d rx_overrun", v), rx_overrun, 0);
            do_ack();
            chk($sformatf("v%0d rx_valid after ack", v), rx_valid, 0);
            chk($sformatf("v%0d rx_data after ack", v), rx_data, 8'hFF);
        end

        // Load while full is ignored.
        load_tx(8'h11);
        load_tx(8'h22);
        chk("full tx_ready", tx_ready, 0);
        select();
        xfer(8'h99, 1'b0, mi, lat);
        deselect();
        chk("full miso keeps first byte", mi, 8'h11);
        chk("full rx_data", rx_data, 8'h99);
        do_ack();

        // Burst with empty holding register, overrun, then ack collision.
        select();
        xfer(8'h12, 1'b0, mi, lat);
        chk("burst miso b0", mi, 8'hFF);
        xfer(8'h34, 1'b0, mi, lat);
        chk("burst miso b1", mi, 8'hFF);
        chk("burst overrun", rx_overrun, 1);
        chk("burst rx_data", rx_data, 8'h34);
        chk("burst rx_valid", rx_valid, 1);
        do_ack();
        chk("burst overrun cleared", rx_overrun, 0);
        chk("burst valid cleared", rx_valid, 0);
        xfer(8'h56, 1'b0, mi, lat);
        chk("burst b2 valid", rx_valid, 1);
        xfer(8'h78, 1'b1, mi, lat);
        chk("collide rx_valid", rx_valid, 1);
        chk("collide rx_overrun", rx_overrun, 0);
        chk("collide rx_data", rx_data, 8'h78);
        deselect();
        do_ack();

        // Abort mid-byte; holding register survives deselect.
        select();
        load_tx(8'h42);
        chk("abort tx_ready loaded", tx_ready, 0);
        partial(8'hF0, 5);
        chk("abort busy mid-byte", busy, 1);
        deselect();
        chk("abort no rx_valid", rx_valid, 0);
        chk("abort busy idle", busy, 0);
        chk("abort hold kept", tx_ready, 0);
        select();
        chk("abort hold consumed", tx_ready, 1);
        xfer(8'h81, 1'b0, mi, lat);
        deselect();
        chk("abort miso", mi, 8'h42);
        chk("abort rx_data", rx_data, 8'h81);
        chk("abort rx_valid", rx_valid, 1);
        chk("abort rx_overrun", rx_overrun, 0);
        do_ack();

        // Reset mid-byte.
        select();
        load_tx(8'h77);
        partial(8'hC3, 3);
        chk("rst busy before", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst miso", miso, 1);
        chk("rst tx_ready", tx_ready, 1);
        chk("rst rx_valid", rx_valid, 0);
        chk("rst rx_data", rx_data, 8'hFF);
        chk("rst rx_overrun", rx_overrun, 0);
        chk("rst busy", busy, 0);
        cs_n = 1'b1;
        sclk = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        select();
        xfer(8'h5A, 1'b0, mi, lat);
        deselect();
        chk("post-rst miso", mi, 8'hFF);
        chk("post-rst rx_data", rx_data, 8'h5A);
        chk("post-rst rx_valid", rx_valid, 1);
        do_ack();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_target.md
# spi_target

SPI mode-0 target (responder): the far end of the SPI initiator byte-exchange interface, for peer/loopback links and for the initiator's verification bench. It oversamples external `sclk`/`cs_n`/`mosi` in the single `clk` domain, shifts one byte MSB-first per 8 `sclk` rising edges, and drives `miso`. It exposes a one-deep transmit holding register and a received-byte register with valid/ack handshakes, matching the initiator's host-side convention (0xFF when no data).

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer depth for `sclk`, `cs_n`, `mosi`; minimum 2.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `sclk`  in  1  SPI clock from initiator, asynchronous; idles low.
- `cs_n`  in  1  chip select, asynchronous, active-low.
- `mosi`  in  1  serial data in, asynchronous.
- `miso`  out  1  serial data out; 1 when not selected.
- `tx_data`  in  8  next byte to transmit.
- `tx_load`  in  1  write `tx_data` into holding register; accepted only when `tx_ready`=1.
- `tx_ready`  out  1  holding register empty.
- `rx_data`  out  8  last received byte; 0xFF while `rx_valid`=0.
- `rx_valid`  out  1  complete byte available.
- `rx_ack`  in  1  consume byte; clears `rx_valid` and `rx_overrun`.
- `rx_overrun`  out  1  sticky: byte completed while `rx_valid` still 1.
- `busy`  out  1  `cs_n` (synced) low and bit counter ≠ 0.

## Operation
- Reset values: `miso`=1, `tx_ready`=1, `rx_valid`=0, `rx_data`=0xFF, `rx_overrun`=0, `busy`=0. Bit counter 0, shift registers 0xFF, state IDLE.
- Reset mid-transfer aborts immediately. A partial byte is dropped and the holding register is emptied.
- States:
  - IDLE → SELECTED on synced `cs_n` fall.
  - SELECTED → IDLE on synced `cs_n` rise, from any bit count.
- Entering SELECTED: `tx_shift` ← holding byte if full, else 0xFF. The holding register empties (`tx_ready`=1). Bit counter ← 0.
- `miso` = `tx_shift[7]` in SELECTED, else 1.
- Synced `sclk` rise in SELECTED:
  - `rx_shift` ← {`rx_shift[6:0]`, `mosi_s`}; counter increments mod 8 (3-bit wrap).
  - If the counter was 7: `rx_data` ← completed byte and `rx_valid` ← 1. If `rx_valid` was already 1 and `rx_ack`=0, set `rx_overrun`; the new byte overwrites.
- Synced `sclk` fall in SELECTED:
  - Counter ≠ 0: `tx_shift` ← {`tx_shift[6:0]`, 1}.
  - Counter = 0 (byte boundary): reload `tx_shift` from holding register (then empty) or 0xFF.
- `cs_n` rise mid-byte: partial `rx_shift` discarded, no `rx_valid`, counter ← 0. The holding register is kept.
- Simultaneous events:
  - `rx_ack` on the same cycle a byte completes: new byte wins, `rx_valid` stays 1, no overrun.
  - `tx_load` on the cycle the holding register is consumed: the consume takes the old content (or 0xFF if empty); the load is accepted only if `tx_ready` was 1 that cycle.
  - `tx_load` while `tx_ready`=0: ignored, holding content unchanged.
- `sclk` edges while IDLE are ignored.

## Timing
- Synchronized edge detect: `sclk_s` = stage `SYNC_STAGES` output; rise = `sclk_s` & ~`sclk_d`.
- Latency from first `clk` edge sampling a pin change to a register update is `SYNC_STAGES`+1 clk edges (3 by default). This applies to `rx_valid`, `miso` transitions and the `cs_n` state change.
- Legal `sclk`: each high/low phase ≥ 4 `clk` periods. `cs_n` setup to first `sclk` rise and hold after last fall: ≥ 4 `clk` periods each.
- `tx_ready` rises the cycle after consumption. `rx_valid` falls the cycle after `rx_ack`. Handshake outputs are registered.

## Structure
- Package `spi_pkg`:
  - `SPI_IDLE_BYTE` = 8'hFF.
  - `spi_target_state_t` {IDLE, SELECTED}.
  - `SPI_SYNC_STAGES_DEFAULT` = 2.
- Sub-module `sync_edge`: N-flop synchronizer plus delay flop, with outputs `level`, `rise`, `fall`. Instantiated for `sclk` and `cs_n`; `mosi` uses its `level` only.

## Test plan
- After reset, `cs_n` high: `miso`=1, `rx_data`=0xFF, `tx_ready`=1, `rx_valid`=0.
- `tx_load` 0xA5, then `cs_n` low and initiator sends 0x3C at clk/8: `miso` shows 1,0,1,0,0,1,0,1; `rx_data`=0x3C; `rx_valid` rises 3 clk after the 8th rise pin sample.
- Empty holding register, 2-byte burst: `miso` reads 0xFF,0xFF. Second byte without `rx_ack` → `rx_overrun`=1, `rx_data`=second byte; `rx_ack` clears both.
- `cs_n` rises after 5 bits of 0xF0, then a full 0x81 transfer: only 0x81 delivered, one `rx_valid`.
- `rx_ack` coincident with byte completion: `rx_valid` stays 1, `rx_overrun`=0. `tx_load` while `tx_ready`=0: holding byte unchanged.
- `rst_n` low mid-byte: next cycle all outputs at reset values. A fresh transfer then works normally.
